// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
// The lockout constants are only used when PARKING_LOCKOUT_EN is defined.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY_OPEN,
        EXIT_OPEN
    } gate_state_e;

    localparam logic [7:0] PASSCODE_DEF    = 8'hFF;
    localparam int         MAX_CARS_DEF    = 20;
    localparam int         GATE_CYCLES_DEF = 3;
    localparam int         TIMER_W         = 8;

    localparam logic [1:0] LOCK_THRESH = 2'd3;
    localparam logic [4:0] LOCK_CYCLES = 5'd16;

endpackage

// File: rtl/parking_gate_timer.sv
// Load/count-down timer shared by both gates; done is high while the count
// is zero, so a load of N-1 gives an N-cycle open window.
import parking_pkg::*;

module parking_gate_timer #(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot entry/exit gate FSM with occupancy count.
// Define PARKING_LOCKOUT_EN to lock out entry after repeated bad passcodes.
import parking_pkg::*;

module parking_gate_ctrl #(
    parameter logic [7:0] PASSCODE    = PASSCODE_DEF,
    parameter int         MAX_CARS    = MAX_CARS_DEF,
    parameter int         GATE_CYCLES = GATE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] passcode_in,
    input  logic       enter_req,
    input  logic       exit_req,
    output logic [4:0] car_count,
    output logic       entry_gate_open,
    output logic       exit_gate_open
);

    localparam logic [4:0]         MAX_C    = 5'(MAX_CARS);
    localparam logic [TIMER_W-1:0] GATE_LD  = TIMER_W'(GATE_CYCLES - 1);

    gate_state_e state_q;
    logic [4:0]  count_q;
    logic        entry_q;
    logic        exit_q;
    logic        locked;
    logic        tmr_done;
    logic        idle;
    logic        grant_exit;
    logic        grant_entry;

    assign idle        = (state_q == IDLE);
    assign grant_exit  = idle && exit_req && (count_q != '0);
    // exit_req always wins the cycle, even when the exit itself is refused
    assign grant_entry = idle && enter_req && !exit_req && !locked &&
                         (passcode_in == PASSCODE) && (count_q < MAX_C);

    parking_gate_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (grant_exit || grant_entry),
        .load_val_i (GATE_LD),
        .en_i       (!idle),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_exit) begin
                        count_q <= count_q - 1'b1;
                        state_q <= EXIT_OPEN;
                        exit_q  <= 1'b1;
                    end else if (grant_entry) begin
                        count_q <= count_q + 1'b1;
                        state_q <= ENTRY_OPEN;
                        entry_q <= 1'b1;
                    end
                end
                ENTRY_OPEN, EXIT_OPEN: begin
                    if (tmr_done) begin
                        state_q <= IDLE;
                        entry_q <= 1'b0;
                        exit_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    entry_q <= 1'b0;
                    exit_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARKING_LOCKOUT_EN
    logic [1:0] fail_q;
    logic [4:0] lock_q;
    logic       wrong_try;

    assign locked    = (lock_q != '0);
    assign wrong_try = idle && enter_req && !exit_req && !locked &&
                       (passcode_in != PASSCODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_q <= '0;
            lock_q <= '0;
        end else if (locked) begin
            lock_q <= lock_q - 1'b1;
            if (lock_q == 5'd1) begin
                fail_q <= '0;
            end
        end else if (grant_entry) begin
            fail_q <= '0;
        end else if (wrong_try) begin
            fail_q <= fail_q + 1'b1;
            if (fail_q == LOCK_THRESH - 2'd1) begin
                lock_q <= LOCK_CYCLES;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

    assign car_count       = count_q;
    assign entry_gate_open = entry_q;
    assign exit_gate_open  = exit_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized bench for parking_gate_ctrl against an event-time reference model.
// Honours PARKING_LOCKOUT_EN the same way the design does.
`timescale 1ns/1ps

module tb_parking_gate_ctrl;

    localparam int G   = 3;
    localparam int MAX = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] passcode_in = '0;
    logic       enter_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [4:0] car_count;
    logic       entry_gate_open;
    logic       exit_gate_open;

    int n_tests = 0;
    int n_fail  = 0;

    // model: edge index, occupancy, edge of last grant and which gate it opened
    int k = 0;
    int m_cnt = 0;
    int m_edge = -100;
    int m_kind = 0;
    int m_fail = 0;
    int m_lock_end = -100;

    parking_gate_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .passcode_in     (passcode_in),
        .enter_req       (enter_req),
        .exit_req        (exit_req),
        .car_count       (car_count),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        m_cnt      = 0;
        m_edge     = -100;
        m_kind     = 0;
        m_fail     = 0;
        m_lock_end = -100;
    endtask

    task automatic model_edge(input bit en, input bit ex, input logic [7:0] code);
        k++;
        if (k < m_edge + G + 1) return;
        if (ex) begin
            if (m_cnt > 0) begin
                m_cnt--;
                m_edge = k;
                m_kind = 2;
            end
            return;
        end
        if (!en) return;
`ifdef PARKING_LOCKOUT_EN
        if (k <= m_lock_end) return;
`endif
        if (code == 8'hFF) begin
            if (m_cnt < MAX) begin
                m_cnt++;
                m_edge = k;
                m_kind = 1;
                m_fail = 0;
            end
        end else begin
`ifdef PARKING_LOCKOUT_EN
            m_fail++;
            if (m_fail == 3) begin
                m_lock_end = k + 16;
                m_fail = 0;
            end
`endif
        end
    endtask

    function automatic bit gate_up(input int kind);
        return (m_kind == kind) && (k >= m_edge) && (k < m_edge + G);
    endfunction

    task automatic compare_all();
        check_eq("car_count", car_count, m_cnt);
        check_eq("entry_gate", entry_gate_open, gate_up(1));
        check_eq("exit_gate", exit_gate_open, gate_up(2));
        check_eq("gate_excl", entry_gate_open & exit_gate_open, 0);
    endtask

    // called at a negedge: drive, clock, model, then compare at next negedge
    task automatic step(input bit en, input bit ex, input logic [7:0] code);
        enter_req   = en;
        exit_req    = ex;
        passcode_in = code;
        @(posedge clk);
        model_edge(en, ex, code);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [7:0] pick_code(input int good_pct);
        if ($urandom_range(0, 99) < good_pct) return 8'hFF;
        return 8'($urandom_range(0, 254));
    endfunction

    task automatic rand_phase(input int n, input int en_pct, input int ex_lo,
                              input int ex_hi, input int good_pct);
        for (int i = 0; i < n; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(r < en_pct, (r >= ex_lo) && (r < ex_hi), pick_code(good_pct));
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b1;
        model_reset();

        // directed: first correct entry, then wrong codes
        step(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'hFE);
        step(1'b1, 1'b0, 8'hEF);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);

        // fill past capacity, drain past empty, then mixed traffic
        rand_phase(200, 70, 97, 100, 95);
        rand_phase(200, 5, 0, 70, 90);
        rand_phase(20, 0, 0, 100, 0);
        rand_phase(400, 45, 30, 60, 75);
        rand_phase(300, 60, 90, 100, 25);
        rand_phase(300, 40, 25, 55, 80);

        // reset while a gate is open must close it at once
        begin
            int waited = 0;
            while (!gate_up(1) && !gate_up(2) && waited < 100) begin
                step(1'b1, 1'b0, 8'hFF);
                waited++;
            end
            check_eq("gate_open_before_rst", gate_up(1) | gate_up(2), 1);
        end
        enter_req = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        rand_phase(300, 50, 40, 60, 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
